// File: rtl/alu_issue_ctrl.sv
// rtl/alu_issue_ctrl.sv - command FIFO plus serial issue FSM sequencing ops into an external ALU
// Holds MULTU for a fixed number of cycles and returns one result per non-multiply op.
module alu_issue_ctrl #(
    parameter int FIFO_DEPTH = 4,
    parameter int MUL_CYCLES = 32
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic [5:0]  cmd_funct,
    input  logic [31:0] cmd_a,
    input  logic [31:0] cmd_b,
    output logic [5:0]  alu_signal,
    output logic [31:0] alu_dataA,
    output logic [31:0] alu_dataB,
    output logic        alu_binvert,
    input  logic [31:0] alu_out,
    output logic        res_valid,
    input  logic        res_ready,
    output logic [31:0] res_data,
    output logic [5:0]  res_funct,
    output logic        res_err,
    output logic        mul_busy
);

    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int CW = $clog2(MUL_CYCLES) + 1;
    localparam logic [PW:0]   DEPTH_C  = (PW + 1)'(FIFO_DEPTH);
    localparam logic [CW-1:0] MUL_LAST = CW'(MUL_CYCLES - 1);

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_EXEC = 3'd1,
        S_CAP  = 3'd2,
        S_MUL  = 3'd3,
        S_RESP = 3'd4
    } state_t;

    state_t state_q, state_d;

    logic [69:0]   fifo_mem_q [FIFO_DEPTH];
    logic [PW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [PW:0]   count_q, count_d;
    logic [CW-1:0] mul_cnt_q, mul_cnt_d;
    logic [5:0]    op_funct_q, op_funct_d;
    logic [31:0]   op_a_q, op_a_d, op_b_q, op_b_d;
    logic [31:0]   res_data_q, res_data_d;
    logic [5:0]    res_funct_q, res_funct_d;
    logic          res_err_q, res_err_d;

    logic          push, pop;
    logic [69:0]   head;
    logic [5:0]    head_funct;

    function automatic logic funct_supported(input logic [5:0] f);
        case (f)
            6'd36, 6'd37, 6'd32, 6'd34, 6'd42, 6'd2, 6'd25, 6'd16, 6'd18: return 1'b1;
            default: return 1'b0;
        endcase
    endfunction

    // A full FIFO refuses input even if the FSM pops on the same edge.
    assign cmd_ready  = !reset && (count_q != DEPTH_C);
    assign push       = cmd_valid && cmd_ready;
    assign pop        = (state_q == S_IDLE) && (count_q != '0);
    assign head       = fifo_mem_q[rd_ptr_q];
    assign head_funct = head[69:64];

    always_ff @(posedge clk) begin
        if (push) begin
            fifo_mem_q[wr_ptr_q] <= {cmd_funct, cmd_a, cmd_b};
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= S_IDLE;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            mul_cnt_q   <= '0;
            op_funct_q  <= '0;
            op_a_q      <= '0;
            op_b_q      <= '0;
            res_data_q  <= '0;
            res_funct_q <= '0;
            res_err_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            mul_cnt_q   <= mul_cnt_d;
            op_funct_q  <= op_funct_d;
            op_a_q      <= op_a_d;
            op_b_q      <= op_b_d;
            res_data_q  <= res_data_d;
            res_funct_q <= res_funct_d;
            res_err_q   <= res_err_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_IDLE: begin
                if (pop) begin
                    if (head_funct == 6'd25)            state_d = S_MUL;
                    else if (!funct_supported(head_funct)) state_d = S_RESP;
                    else                                state_d = S_EXEC;
                end
            end
            S_EXEC:  state_d = S_CAP;
            S_CAP:   state_d = S_RESP;
            S_MUL:   if (mul_cnt_q == MUL_LAST) state_d = S_IDLE;
            S_RESP:  if (res_ready) state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        wr_ptr_d    = push ? wr_ptr_q + 1'b1 : wr_ptr_q;
        rd_ptr_d    = pop  ? rd_ptr_q + 1'b1 : rd_ptr_q;
        count_d     = count_q + {{PW{1'b0}}, push} - {{PW{1'b0}}, pop};
        mul_cnt_d   = (state_q == S_MUL && state_d == S_MUL) ? mul_cnt_q + 1'b1 : '0;
        op_funct_d  = op_funct_q;
        op_a_d      = op_a_q;
        op_b_d      = op_b_q;
        res_data_d  = res_data_q;
        res_funct_d = res_funct_q;
        res_err_d   = res_err_q;
        if (pop) begin
            op_funct_d = head_funct;
            op_a_d     = head[63:32];
            op_b_d     = head[31:0];
            if (!funct_supported(head_funct)) begin
                res_data_d  = '0;
                res_funct_d = head_funct;
                res_err_d   = 1'b1;
            end
        end else if (state_q == S_CAP) begin
            res_data_d  = alu_out;
            res_funct_d = op_funct_q;
            res_err_d   = 1'b0;
        end
    end

    always_comb begin
        alu_signal  = '0;
        alu_dataA   = '0;
        alu_dataB   = '0;
        alu_binvert = 1'b0;
        res_valid   = 1'b0;
        mul_busy    = 1'b0;
        case (state_q)
            S_EXEC, S_CAP, S_MUL: begin
                alu_signal  = op_funct_q;
                alu_dataA   = op_a_q;
                alu_dataB   = op_b_q;
                alu_binvert = (op_funct_q == 6'd34) || (op_funct_q == 6'd42);
                mul_busy    = (state_q == S_MUL);
            end
            S_RESP:  res_valid = 1'b1;
            default: ;
        endcase
    end

    assign res_data  = res_data_q;
    assign res_funct = res_funct_q;
    assign res_err   = res_err_q;

endmodule

// File: tb/tb_alu_issue_ctrl.sv
// tb/tb_alu_issue_ctrl.sv - randomized and directed self-checking bench for alu_issue_ctrl
module tb_alu_issue_ctrl;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        cmd_valid = 1'b0;
    logic        cmd_ready;
    logic [5:0]  cmd_funct = '0;
    logic [31:0] cmd_a = '0;
    logic [31:0] cmd_b = '0;
    logic [5:0]  alu_signal;
    logic [31:0] alu_dataA, alu_dataB, alu_out;
    logic        alu_binvert;
    logic        res_valid;
    logic        res_ready = 1'b0;
    logic [31:0] res_data;
    logic [5:0]  res_funct;
    logic        res_err;
    logic        mul_busy;

    alu_issue_ctrl #(.FIFO_DEPTH(4), .MUL_CYCLES(32)) dut (
        .clk(clk), .reset(reset),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_funct(cmd_funct), .cmd_a(cmd_a), .cmd_b(cmd_b),
        .alu_signal(alu_signal), .alu_dataA(alu_dataA), .alu_dataB(alu_dataB),
        .alu_binvert(alu_binvert), .alu_out(alu_out),
        .res_valid(res_valid), .res_ready(res_ready),
        .res_data(res_data), .res_funct(res_funct), .res_err(res_err),
        .mul_busy(mul_busy)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad = 0;
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // External ALU: subtraction and SLT only work when binvert is asserted.
    logic [31:0] alu_hi = '0, alu_lo = '0;
    always @(posedge clk) begin
        if (alu_signal == 6'd25) {alu_hi, alu_lo} <= {32'd0, alu_dataA} * {32'd0, alu_dataB};
    end
    always_comb begin
        alu_out = '0;
        case (alu_signal)
            6'd36: alu_out = alu_dataA & alu_dataB;
            6'd37: alu_out = alu_dataA | alu_dataB;
            6'd32, 6'd34: alu_out = alu_dataA + (alu_binvert ? ~alu_dataB : alu_dataB) + {31'd0, alu_binvert};
            6'd42: alu_out = {31'd0, alu_binvert && ($signed(alu_dataA) < $signed(alu_dataB))};
            6'd2:  alu_out = alu_dataA >> alu_dataB[4:0];
            6'd16: alu_out = alu_hi;
            6'd18: alu_out = alu_lo;
            default: alu_out = '0;
        endcase
    end

    typedef struct packed {
        logic [31:0] d;
        logic [5:0]  f;
        logic        e;
    } exp_t;

    exp_t        exp_q[$];
    logic [31:0] log_d[$];
    logic [5:0]  log_f[$];
    logic        log_e[$];
    logic [31:0] m_hi = '0, m_lo = '0;
    int acc_cyc = 0, mul_acc_cyc = 0, first_valid_cyc = 0;
    int mul_start = 0, mul_run = 0, mul_last_run = 0;
    bit mul_prev = 0, res_prev = 0, rand_rdy = 0;
    int sig_cycles[64];
    int binv_cycles[64];

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    task automatic fail_now(input string name);
        total++;
        bad++;
        $display("FAIL %s: condition not met", name);
    endtask

    // Program-order reference: results computed from operands at accept time.
    task automatic model_accept(input logic [5:0] f, input logic [31:0] a, input logic [31:0] b);
        exp_t e;
        if (f == 6'd25) begin
            {m_hi, m_lo} = {32'd0, a} * {32'd0, b};
        end else begin
            e.f = f;
            e.e = 1'b0;
            case (f)
                6'd36: e.d = a & b;
                6'd37: e.d = a | b;
                6'd32: e.d = a + b;
                6'd34: e.d = a - b;
                6'd42: e.d = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
                6'd2:  e.d = a >> b[4:0];
                6'd16: e.d = m_hi;
                6'd18: e.d = m_lo;
                default: begin e.d = '0; e.e = 1'b1; end
            endcase
            exp_q.push_back(e);
        end
    endtask

    initial begin
        forever begin
            @(negedge clk);
            if (reset) begin
                exp_q.delete();
                mul_run = 0;
                mul_prev = 0;
                res_prev = 0;
            end else begin
                chk("binvert_rule", {31'd0, alu_binvert}, {31'd0, (alu_signal == 6'd34) || (alu_signal == 6'd42)});
                sig_cycles[alu_signal]++;
                if (alu_binvert) binv_cycles[alu_signal]++;
                if (mul_busy) begin
                    chk("mul_signal", {26'd0, alu_signal}, 32'd25);
                    if (!mul_prev) mul_start = cyc;
                    mul_run++;
                end else if (mul_prev) begin
                    mul_last_run = mul_run;
                    mul_run = 0;
                end
                mul_prev = mul_busy;
                if (res_valid) begin
                    if (!res_prev) first_valid_cyc = cyc;
                    chk("resp_alu_signal", {26'd0, alu_signal}, 32'd0);
                    chk("resp_alu_a", alu_dataA, 32'd0);
                    if (exp_q.size() == 0) begin
                        fail_now("unexpected_result");
                    end else begin
                        chk("res_data", res_data, exp_q[0].d);
                        chk("res_funct", {26'd0, res_funct}, {26'd0, exp_q[0].f});
                        chk("res_err", {31'd0, res_err}, {31'd0, exp_q[0].e});
                        if (res_ready) void'(exp_q.pop_front());
                    end
                    if (res_ready) begin
                        log_d.push_back(res_data);
                        log_f.push_back(res_funct);
                        log_e.push_back(res_err);
                    end
                end
                res_prev = res_valid;
                if (cmd_valid && cmd_ready) begin
                    acc_cyc = cyc + 1;
                    if (cmd_funct == 6'd25) mul_acc_cyc = cyc + 1;
                    model_accept(cmd_funct, cmd_a, cmd_b);
                end
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
        if (rand_rdy) res_ready = ($urandom_range(0, 3) != 0);
    endtask

    task automatic push(input logic [5:0] f, input logic [31:0] a, input logic [31:0] b);
        int n = 0;
        cmd_funct = f;
        cmd_a = a;
        cmd_b = b;
        cmd_valid = 1'b1;
        while (!cmd_ready && n < 400) begin
            step();
            n++;
        end
        if (!cmd_ready) begin
            fail_now("push_timeout");
            cmd_valid = 1'b0;
            return;
        end
        step();
        cmd_valid = 1'b0;
    endtask

    task automatic wait_log(input int n, input int budget);
        int k = 0;
        while (log_d.size() < n && k < budget) begin
            step();
            k++;
        end
        if (log_d.size() < n) fail_now("result_timeout");
    endtask

    initial begin
        int base, k;
        int b34, b42, b36, s36;
        logic [31:0] hold;
        logic [5:0] ftab [11];
        ftab = '{6'd36, 6'd37, 6'd32, 6'd34, 6'd42, 6'd2, 6'd25, 6'd16, 6'd18, 6'd63, 6'd0};

        repeat (3) step();
        chk("rst_cmd_ready", {31'd0, cmd_ready}, 32'd0);
        chk("rst_res_valid", {31'd0, res_valid}, 32'd0);
        chk("rst_mul_busy", {31'd0, mul_busy}, 32'd0);
        chk("rst_alu_signal", {26'd0, alu_signal}, 32'd0);
        chk("rst_alu_a", alu_dataA, 32'd0);
        chk("rst_res_data", res_data, 32'd0);
        reset = 1'b0;
        #1;
        chk("post_rst_ready", {31'd0, cmd_ready}, 32'd1);

        res_ready = 1'b1;
        base = log_d.size();
        push(6'd32, 32'd5, 32'd7);
        wait_log(base + 1, 20);
        chk("add_latency", first_valid_cyc - acc_cyc, 32'd3);
        if (log_d.size() > base) begin
            chk("add_data", log_d[base], 32'd12);
            chk("add_funct", {26'd0, log_f[base]}, 32'd32);
            chk("add_err", {31'd0, log_e[base]}, 32'd0);
        end

        b34 = binv_cycles[34]; b42 = binv_cycles[42]; b36 = binv_cycles[36]; s36 = sig_cycles[36];
        base = log_d.size();
        push(6'd34, 32'd10, 32'd3);
        push(6'd42, 32'd3, 32'd10);
        push(6'd36, 32'd12, 32'd10);
        wait_log(base + 3, 40);
        if (log_d.size() >= base + 3) begin
            chk("sub_data", log_d[base], 32'd7);
            chk("slt_data", log_d[base + 1], 32'd1);
            chk("and_data", log_d[base + 2], 32'd8);
        end
        chk("binv_sub_cycles", binv_cycles[34] - b34, 32'd2);
        chk("binv_slt_cycles", binv_cycles[42] - b42, 32'd2);
        chk("binv_and_cycles", binv_cycles[36] - b36, 32'd0);
        chk("and_issue_cycles", sig_cycles[36] - s36, 32'd2);

        base = log_d.size();
        push(6'd25, 32'd65536, 32'd65536);
        push(6'd16, 32'd0, 32'd0);
        push(6'd18, 32'd0, 32'd0);
        wait_log(base + 2, 200);
        chk("mul_busy_len", mul_last_run, 32'd32);
        chk("mul_busy_start", mul_start - mul_acc_cyc, 32'd1);
        if (log_d.size() >= base + 2) begin
            chk("mfhi_data", log_d[base], 32'd1);
            chk("mfhi_funct", {26'd0, log_f[base]}, 32'd16);
            chk("mflo_data", log_d[base + 1], 32'd0);
            chk("mflo_funct", {26'd0, log_f[base + 1]}, 32'd18);
        end

        res_ready = 1'b0;
        base = log_d.size();
        for (int i = 1; i <= 5; i++) push(6'd32, i, i);
        chk("full_ready", {31'd0, cmd_ready}, 32'd0);
        hold = res_data;
        chk("held_first", hold, 32'd2);
        cmd_funct = 6'd32; cmd_a = 32'd99; cmd_b = 32'd99; cmd_valid = 1'b1;
        repeat (8) begin
            step();
            chk("full_hold_ready", {31'd0, cmd_ready}, 32'd0);
            chk("hold_valid", {31'd0, res_valid}, 32'd1);
            chk("hold_data", res_data, hold);
        end
        cmd_valid = 1'b0;
        res_ready = 1'b1;
        wait_log(base + 5, 100);
        repeat (10) step();
        chk("drain_count", log_d.size() - base, 32'd5);
        if (log_d.size() >= base + 5)
            for (int j = 0; j < 5; j++) chk("drain_order", log_d[base + j], 2 * (j + 1));

        base = log_d.size();
        push(6'd63, 32'd1, 32'd2);
        push(6'd32, 32'd3, 32'd4);
        wait_log(base + 2, 30);
        if (log_d.size() >= base + 2) begin
            chk("err_flag", {31'd0, log_e[base]}, 32'd1);
            chk("err_data", log_d[base], 32'd0);
            chk("err_funct", {26'd0, log_f[base]}, 32'd63);
            chk("after_err_data", log_d[base + 1], 32'd7);
            chk("after_err_flag", {31'd0, log_e[base + 1]}, 32'd0);
        end

        push(6'd25, 32'd3, 32'd5);
        push(6'd32, 32'd1, 32'd1);
        push(6'd32, 32'd2, 32'd2);
        k = 0;
        while (mul_run < 10 && k < 50) begin step(); k++; end
        if (mul_run < 10) fail_now("mul_start_timeout");
        reset = 1'b1;
        step();
        reset = 1'b0;
        #1;
        chk("abort_mul_busy", {31'd0, mul_busy}, 32'd0);
        chk("abort_res_valid", {31'd0, res_valid}, 32'd0);
        chk("abort_ready", {31'd0, cmd_ready}, 32'd1);
        base = log_d.size();
        repeat (60) step();
        chk("abort_no_results", log_d.size() - base, 32'd0);
        chk("abort_mul_idle", {31'd0, mul_busy}, 32'd0);

        rand_rdy = 1;
        repeat (150) begin
            push(ftab[$urandom_range(0, 10)], $urandom, $urandom);
            if ($urandom_range(0, 2) == 0) repeat ($urandom_range(1, 3)) step();
        end
        rand_rdy = 0;
        res_ready = 1'b1;
        k = 0;
        while ((exp_q.size() != 0 || mul_busy) && k < 2000) begin step(); k++; end
        repeat (5) step();
        chk("final_drain", exp_q.size(), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #800000;
        $display("FAIL watchdog: simulation did not finish in time");
        $display("test done: total=%0d bad=%0d", total, bad + 1);
        $fatal(1);
    end

endmodule

// File: doc/alu_issue_ctrl.md
ALU_ISSUE_CTRL -- requirements
Module: alu_issue_ctrl

Interface
REQ-001 SHALL have parameter FIFO_DEPTH, default 4, command FIFO entries (power of two, >=2).
REQ-002 SHALL have parameter MUL_CYCLES, default 32, cycles Signal=25 is held for a MULTU.
REQ-003 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-004 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-005 SHALL have port cmd_valid  input  1  command offered.
REQ-006 SHALL have port cmd_ready  output  1  FIFO can accept a command.
REQ-007 SHALL have port cmd_funct  input  6  operation code: AND 36, OR 37, ADD 32, SUB 34, SLT 42, SRL 2, MULTU 25, MFHI 16, MFLO 18.
REQ-008 SHALL have port cmd_a  input  32  operand A.
REQ-009 SHALL have port cmd_b  input  32  operand B.
REQ-010 SHALL have port alu_signal  output  6  funct driven to ALU Signal.
REQ-011 SHALL have port alu_dataA  output  32  ALU operand A.
REQ-012 SHALL have port alu_dataB  output  32  ALU operand B.
REQ-013 SHALL have port alu_binvert  output  1  ALU B-invert control.
REQ-014 SHALL have port alu_out  input  32  ALU Output.
REQ-015 SHALL have port res_valid  output  1  result available.
REQ-016 SHALL have port res_ready  input  1  consumer accepts result.
REQ-017 SHALL have port res_data  output  32  result value.
REQ-018 SHALL have port res_funct  output  6  funct of the op that produced res_data.
REQ-019 SHALL have port res_err  output  1  op had unsupported funct; res_data=0.
REQ-020 SHALL have port mul_busy  output  1  MULTU in progress.

Function
REQ-021 SHALL accept a command on a rising edge where cmd_valid && cmd_ready; cmd_ready = FIFO not full; no bypass when full, even if a pop occurs the same cycle.
REQ-022 SHALL issue in FIFO order, one op at a time, via FSM states IDLE, EXEC, CAP, MUL, RESP.
REQ-023 SHALL, in IDLE with FIFO non-empty, pop head and go to MUL if funct=25, to RESP with res_err=1 if funct unsupported, else to EXEC.
REQ-024 SHALL drive alu_signal/dataA/dataB from the latched op during EXEC, CAP and MUL; in IDLE and RESP drive alu_signal=0, dataA=0, dataB=0, binvert=0.
REQ-025 SHALL set alu_binvert=1 only for funct 34 and 42, else 0; never sticky across ops.
REQ-026 SHALL stay exactly one cycle in EXEC, then one cycle in CAP, registering alu_out into res_data on the edge leaving CAP; next state RESP.
REQ-027 SHALL hold MUL for exactly MUL_CYCLES cycles using a counter (width clog2(MUL_CYCLES)+1), assert mul_busy throughout, produce no result, then return to IDLE.
REQ-028 SHALL treat MFHI/MFLO as normal EXEC/CAP ops; because issue is serial, an MFHI/MFLO queued behind a MULTU issues only after MUL completes.
REQ-029 SHALL assert res_valid only in RESP; hold res_data/res_funct/res_err stable until res_valid && res_ready, then go to IDLE the next edge.
REQ-030 SHALL give latency: command accepted at edge N into empty FIFO, idle FSM -> res_valid high after edge N+3; MULTU -> mul_busy high after edge N+1 through edge N+1+MUL_CYCLES.
REQ-031 SHALL keep accepting commands while busy until FIFO full; FIFO pointers wrap modulo FIFO_DEPTH; occupancy counter distinguishes full/empty.
REQ-032 SHALL allow push and pop in the same cycle when not full, occupancy unchanged.

Reset
REQ-033 SHALL, while reset is high at a rising edge, empty the FIFO, enter IDLE, clear MUL counter, and drive cmd_ready=0, res_valid=0, res_data=0, res_funct=0, res_err=0, mul_busy=0, alu_* = 0.
REQ-034 SHALL abort any in-flight op (including mid-MULTU or pending RESP) on reset; cmd_ready=1 on the first cycle after reset deasserts.

Verification
REQ-035 SHALL pass: ADD a=5 b=7, res_ready=1 -> res_valid 3 cycles after accept, res_data=12, res_funct=32, res_err=0.
REQ-036 SHALL pass: SUB 10,3 then SLT 3,10 then AND 12,10 back-to-back -> results 7,1,8 in order, binvert 1,1,0 during each EXEC/CAP.
REQ-037 SHALL pass: MULTU 65536,65536 then MFHI then MFLO -> mul_busy 32 cycles, no result for MULTU, then results 1 and 0.
REQ-038 SHALL pass: push 5 commands with res_ready=0 -> cmd_ready low after 4 buffered + 1 in FSM pending; res_data held stable; release drains all in order.
REQ-039 SHALL pass: funct 63 -> res_err=1, res_data=0, next command unaffected.
REQ-040 SHALL pass: reset asserted at MUL cycle 10 with 2 queued -> mul_busy=0, FIFO empty, no results emitted afterward.
